timer_dev: RTL and testbench



---
 rtl/timer_dev.sv | 99 +++++++++
 tb/tb_timer_dev.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Programmable 32-bit down-counting timer on the bridge bus: CTRL/PRESET/COUNT
// registers, one-shot and auto-reload modes, maskable level IRQ.
module timer_dev (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIN,
  output logic [31:0] DOUT,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_e;

  state_e      state_q;
  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        pending_q;
  logic        irq_q;

  logic ctrlWr;
  logic presetWr;
  logic en_d;
  logic oneShot;

  assign ctrlWr   = WE && (Addr == 2'd0);
  assign presetWr = WE && (Addr == 2'd1);
  // The FSM follows the enable as it will be after this edge, so a CTRL write
  // starts or stops the counter on the very edge that stores it.
  assign en_d     = ctrlWr ? DIN[0] : ctrl_q[0];
  assign oneShot  = (ctrl_q[2:1] != 2'b01);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= 4'd0;
      preset_q  <= 32'd0;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (ctrlWr) ctrl_q <= DIN[3:0];
      if (presetWr) preset_q <= DIN;
      if (ctrlWr || presetWr) pending_q <= 1'b0;
      irq_q <= pending_q & ctrl_q[3];

      // Later assignments below take priority over the bus-side updates above.
      case (state_q)
        S_IDLE: begin
          if (en_d) state_q <= S_LOAD;
        end
        S_LOAD: begin
          count_q <= preset_q;
          state_q <= en_d ? S_CNT : S_IDLE;
        end
        S_CNT: begin
          if (!en_d) begin
            state_q <= S_IDLE;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            count_q   <= 32'd0;
            state_q   <= S_INT;
            pending_q <= 1'b1;
            if (oneShot && !ctrlWr) ctrl_q[0] <= 1'b0;
          end
        end
        S_INT: begin
          if (oneShot) begin
            state_q <= S_IDLE;
          end else begin
            pending_q <= 1'b0;
            state_q   <= en_d ? S_LOAD : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    DOUT = 32'd0;
    case (Addr)
      2'd0:    DOUT = {28'd0, ctrl_q};
      2'd1:    DOUT = preset_q;
      2'd2:    DOUT = count_q;
      default: DOUT = 32'd0;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: a vector table for reset, one-shot and
// auto-reload runs, then directed sequences for masking, stop and collisions.
module tb_timer_dev;

  logic        Clk;
  logic        Reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIN;
  logic [31:0] DOUT;
  logic        IRQ;

  int total;
  int bad;

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [1:0]  rdA;
    logic [31:0] expRd;
    logic        expIrq;
  } vec_t;

  vec_t vecs[$];

  timer_dev dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Addr (Addr),
    .WE   (WE),
    .DIN  (DIN),
    .DOUT (DOUT),
    .IRQ  (IRQ)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  function automatic void addVec(input string name, input logic rst, input logic we,
                                 input logic [1:0] addr, input logic [31:0] din,
                                 input logic [1:0] rdA, input logic [31:0] expRd,
                                 input logic expIrq);
    vec_t v;
    v.name = name; v.rst = rst; v.we = we; v.addr = addr; v.din = din;
    v.rdA = rdA; v.expRd = expRd; v.expIrq = expIrq;
    vecs.push_back(v);
  endfunction

  // Drive one bus cycle on the falling edge, let the rising edge take it,
  // then release the write strobe so later read-address changes are harmless.
  task automatic applyStimulus(input logic rst, input logic we, input logic [1:0] addr,
                               input logic [31:0] din);
    @(negedge Clk);
    Reset = rst;
    WE    = we;
    Addr  = addr;
    DIN   = din;
    @(posedge Clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] rdA,
                             input logic [31:0] expRd, input logic expIrq);
    Addr = rdA;
    #1;
    total++;
    if (DOUT !== expRd || IRQ !== expIrq) begin
      bad++;
      $display("[TB] FAIL %s: got DOUT=%h IRQ=%b, want DOUT=%h IRQ=%b",
               name, DOUT, IRQ, expRd, expIrq);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset = 1'b1;
    WE    = 1'b0;
    Addr  = 2'd0;
    DIN   = 32'd0;

    // Reset with a colliding CTRL write, then a one-shot run of PRESET=3.
    addVec("rst_ctrl",    1, 1, 2'd0, 32'hF, 2'd0, 32'h0, 0);
    addVec("rst_count",   1, 0, 2'd0, 32'h0, 2'd2, 32'h0, 0);
    addVec("rst_preset",  0, 0, 2'd0, 32'h0, 2'd1, 32'h0, 0);
    addVec("os_preset",   0, 1, 2'd1, 32'h3, 2'd1, 32'h3, 0);
    addVec("os_start",    0, 1, 2'd0, 32'h9, 2'd0, 32'h9, 0);
    addVec("os_cnt3",     0, 0, 2'd0, 32'h0, 2'd2, 32'h3, 0);
    addVec("os_cnt2",     0, 0, 2'd0, 32'h0, 2'd2, 32'h2, 0);
    addVec("os_cnt1",     0, 0, 2'd0, 32'h0, 2'd2, 32'h1, 0);
    addVec("os_cnt0",     0, 0, 2'd0, 32'h0, 2'd2, 32'h0, 0);
    addVec("os_ctrl8",    0, 0, 2'd0, 32'h0, 2'd0, 32'h8, 1);
    addVec("os_irqhold",  0, 0, 2'd0, 32'h0, 2'd2, 32'h0, 1);
    addVec("os_prewr",    0, 1, 2'd1, 32'h5, 2'd1, 32'h5, 1);
    addVec("os_irqdrop",  0, 0, 2'd0, 32'h0, 2'd0, 32'h8, 0);
    // Auto-reload, PRESET=2: period of four cycles, three full periods.
    addVec("ar_preset",   0, 1, 2'd1, 32'h2, 2'd1, 32'h2, 0);
    addVec("ar_start",    0, 1, 2'd0, 32'hB, 2'd0, 32'hB, 0);
    for (int p = 0; p < 3; p++) begin
      addVec($sformatf("ar_p%0d_c2", p), 0, 0, 2'd0, 32'h0, 2'd2, 32'h2, 0);
      addVec($sformatf("ar_p%0d_c1", p), 0, 0, 2'd0, 32'h0, 2'd2, 32'h1, 0);
      addVec($sformatf("ar_p%0d_c0", p), 0, 0, 2'd0, 32'h0, 2'd2, 32'h0, 0);
      addVec($sformatf("ar_p%0d_irq", p), 0, 0, 2'd0, 32'h0, 2'd2, 32'h0, 1);
    end
    addVec("ar_c2_again", 0, 0, 2'd0, 32'h0, 2'd2, 32'h2, 0);
    addVec("ar_stop",     0, 1, 2'd0, 32'h0, 2'd0, 32'h0, 0);
    addVec("ar_hold",     0, 0, 2'd0, 32'h0, 2'd2, 32'h2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].din);
      checkOutput(vecs[i].name, vecs[i].rdA, vecs[i].expRd, vecs[i].expIrq);
    end

    // Masked one-shot: expiry never raises IRQ, and a CTRL=0x8 write clears pending.
    applyStimulus(1'b0, 1'b1, 2'd1, 32'h2);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h1);
    idle(); checkOutput("mask_c2", 2'd2, 32'h2, 1'b0);
    idle(); checkOutput("mask_c1", 2'd2, 32'h1, 1'b0);
    idle(); checkOutput("mask_expire", 2'd0, 32'h0, 1'b0);
    idle(); checkOutput("mask_noirq1", 2'd2, 32'h0, 1'b0);
    idle(); checkOutput("mask_noirq2", 2'd2, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h8);
    for (int k = 0; k < 3; k++) begin
      idle(); checkOutput($sformatf("mask_after_im%0d", k), 2'd0, 32'h8, 1'b0);
    end

    // Unmasked expiry, then IM cleared: IRQ is gone one edge after the write.
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h9);
    idle(); idle();
    idle(); checkOutput("im_expire", 2'd0, 32'h8, 1'b0);
    idle(); checkOutput("im_irq_up", 2'd0, 32'h8, 1'b1);
    idle(); checkOutput("im_irq_hold", 2'd2, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h0);
    idle(); checkOutput("im_irq_drop", 2'd0, 32'h0, 1'b0);

    // Stop mid-count at COUNT=6, then re-enable to reload PRESET.
    applyStimulus(1'b0, 1'b1, 2'd1, 32'd10);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h9);
    for (int k = 0; k < 5; k++) begin
      idle(); checkOutput($sformatf("stop_cnt%0d", 10 - k), 2'd2, 32'd10 - k, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h8);
    checkOutput("stop_at6", 2'd2, 32'd6, 1'b0);
    idle(); checkOutput("stop_hold1", 2'd2, 32'd6, 1'b0);
    idle(); checkOutput("stop_hold2", 2'd2, 32'd6, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h9);
    idle(); checkOutput("stop_reload", 2'd2, 32'd10, 1'b0);
    idle(); checkOutput("stop_recount", 2'd2, 32'd9, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h0);
    checkOutput("stop_again", 2'd2, 32'd9, 1'b0);

    // CTRL write in the exact expiry cycle: written value kept, pending still set.
    applyStimulus(1'b0, 1'b1, 2'd1, 32'h2);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h1);
    idle(); checkOutput("col_c2", 2'd2, 32'h2, 1'b0);
    idle(); checkOutput("col_c1", 2'd2, 32'h1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h9);
    checkOutput("col_ctrl_kept", 2'd0, 32'h9, 1'b0);
    checkOutput("col_count0", 2'd2, 32'h0, 1'b0);
    idle(); checkOutput("col_pending_irq", 2'd0, 32'h9, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h0);
    idle(); checkOutput("col_cleared", 2'd0, 32'h0, 1'b0);

    // PRESET=0: a single CNT cycle, then INT.
    applyStimulus(1'b0, 1'b1, 2'd1, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h9);
    idle(); checkOutput("p0_cnt", 2'd0, 32'h9, 1'b0);
    idle(); checkOutput("p0_int", 2'd0, 32'h8, 1'b0);
    idle(); checkOutput("p0_irq", 2'd2, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h0);
    idle(); checkOutput("p0_cleared", 2'd0, 32'h0, 1'b0);

    // Writes to COUNT and the reserved address change nothing.
    applyStimulus(1'b0, 1'b1, 2'd1, 32'h55);
    checkOutput("ign_preset", 2'd1, 32'h55, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd2, 32'hDEADBEEF);
    checkOutput("ign_count", 2'd2, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h12345678);
    checkOutput("ign_rsvd", 2'd3, 32'h0, 1'b0);
    checkOutput("ign_rsvd_ctrl", 2'd0, 32'h0, 1'b0);
    checkOutput("ign_rsvd_preset", 2'd1, 32'h55, 1'b0);
    checkOutput("ign_rsvd_count", 2'd2, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
